seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 26 ++
 rtl/seq_alu_if.sv | 37 +++
 rtl/seq_muldiv.sv | 79 +++++++
 rtl/seq_alu.sv | 167 ++++++++++++++++
 tb/tb_seq_alu.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state type for the sequential ALU and its
// iterative multiply/divide engine.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_NEG  = 5'b00010;
  localparam logic [4:0] OP_SCMP = 5'b01011;
  localparam logic [4:0] OP_UCMP = 5'b01111;
  localparam logic [4:0] OP_AND  = 5'b10000;
  localparam logic [4:0] OP_OR   = 5'b10101;
  localparam logic [4:0] OP_XOR  = 5'b11100;
  localparam logic [4:0] OP_NOT  = 5'b10110;
  localparam logic [4:0] OP_ARS  = 5'b11010;
  localparam logic [4:0] OP_LRS  = 5'b11000;
  localparam logic [4:0] OP_LROT = 5'b11110;
  localparam logic [4:0] OP_RROT = 5'b11101;
  localparam logic [4:0] OP_MUL  = 5'b00100;
  localparam logic [4:0] OP_DIV  = 5'b00101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle of the sequential ALU, with the controlling side
// (master) and the ALU side (slave) as modports.
interface seq_alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
);
  // Handshake: start is taken on a rising edge only while busy=0; busy covers
  // multi-cycle ops; done pulses one cycle and results hold until the next done.
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_hi;
  logic             overflow;
  logic             less;
  logic             equal;
  logic             greater;
  logic             zero;
  logic             div_by_zero;
  alu_state_e       state_dbg;

  modport master (
    output start, op, a, b,
    input  busy, done, q, q_hi, overflow, less, equal, greater, zero,
           div_by_zero, state_dbg
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, q, q_hi, overflow, less, equal, greater, zero,
           div_by_zero, state_dbg
  );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit
// per step, with a saturating iteration counter.
module seq_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div_mode,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum, shifted;

    // hi:lo is the running product (multiplier consumed from lo) or the
    // remainder:dividend pair whose lo fills with quotient bits.
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        sum     = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        if (load) begin
            hi_d   = '0;
            lo_d   = a;
            opnd_d = b;
            div_d  = is_div;
            cnt_d  = '0;
        end else if (step && (cnt_q != CW'(WIDTH))) begin
            cnt_d = cnt_q + CW'(1);
            if (div_q) begin
                if (shifted >= {1'b0, opnd_q}) begin
                    hi_d = WIDTH'(shifted - {1'b0, opnd_q});
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign div_mode = div_q;
    assign last     = step && (cnt_q == CW'(WIDTH - 1));
    assign res_hi   = hi_d;
    assign res_lo   = lo_d;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus WIDTH-step
// multiply and divide, with registered result and flag outputs.
module seq_alu
  import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, hi_q, hi_d;
    logic             ovf_q, ovf_d, lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic             zero_q, zero_d, dbz_q, dbz_d, done_q, done_d;
    logic [WIDTH-1:0] sc_q, sc_hi;
    logic             sc_ovf, sc_lt, sc_eq, sc_gt, sc_dbz;
    logic [WIDTH:0]   sum;
    logic             needs_run;
    logic             md_load, md_step, md_div, md_last;
    logic [WIDTH-1:0] md_hi, md_lo;

    always_comb begin
        sc_q   = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_lt  = 1'b0;
        sc_eq  = 1'b0;
        sc_gt  = 1'b0;
        sc_dbz = 1'b0;
        sum    = {1'b0, bus.a} + {1'b0, bus.b};
        case (bus.op)
            OP_ADD:  begin sc_q = sum[WIDTH-1:0]; sc_ovf = sum[WIDTH]; end
            OP_SUB:  begin sc_q = bus.a - bus.b; sc_ovf = (bus.a >= bus.b); end
            OP_NEG:  sc_q = '0 - bus.b;
            OP_SCMP: begin
                sc_q  = bus.a - bus.b;
                sc_lt = ($signed(bus.a) < $signed(bus.b));
                sc_eq = (bus.a == bus.b);
                sc_gt = ($signed(bus.a) > $signed(bus.b));
            end
            OP_UCMP: begin
                sc_q  = bus.a - bus.b;
                sc_lt = (bus.a < bus.b);
                sc_eq = (bus.a == bus.b);
                sc_gt = (bus.a > bus.b);
            end
            OP_AND:  sc_q = bus.a & bus.b;
            OP_OR:   sc_q = bus.a | bus.b;
            OP_XOR:  sc_q = bus.a ^ bus.b;
            OP_NOT:  sc_q = ~bus.b;
            OP_ARS:  begin sc_q = {bus.b[WIDTH-1], bus.b[WIDTH-1:1]}; sc_ovf = bus.b[0]; end
            OP_LRS:  begin sc_q = {1'b0, bus.b[WIDTH-1:1]}; sc_ovf = bus.b[0]; end
            OP_LROT: sc_q = {bus.b[WIDTH-2:0], bus.b[WIDTH-1]};
            OP_RROT: sc_q = {bus.b[0], bus.b[WIDTH-1:1]};
            // Only the divide-by-zero case of DIV finishes in one cycle.
            OP_DIV:  begin sc_q = '1; sc_hi = bus.a; sc_dbz = 1'b1; end
            default: ;
        endcase
    end

    assign needs_run = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0));

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        md_load = 1'b0;
        md_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (needs_run) begin
                        md_load = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                        q_d    = sc_q;
                        hi_d   = sc_hi;
                        ovf_d  = sc_ovf;
                        lt_d   = sc_lt;
                        eq_d   = sc_eq;
                        gt_d   = sc_gt;
                        dbz_d  = sc_dbz;
                        zero_d = (sc_q == '0) && (sc_hi == '0);
                    end
                end
            end
            ST_RUN: begin
                md_step = 1'b1;
                if (md_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    q_d     = md_lo;
                    hi_d    = md_hi;
                    ovf_d   = !md_div && (md_hi != '0);
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    dbz_d   = 1'b0;
                    zero_d  = (md_lo == '0) && (md_hi == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .load    (md_load),
        .step    (md_step),
        .is_div  (bus.op == OP_DIV),
        .a       (bus.a),
        .b       (bus.b),
        .div_mode(md_div),
        .last    (md_last),
        .res_hi  (md_hi),
        .res_lo  (md_lo)
    );

    assign bus.busy        = (state_q == ST_RUN);
    assign bus.done        = done_q;
    assign bus.q           = q_q;
    assign bus.q_hi        = hi_q;
    assign bus.overflow    = ovf_q;
    assign bus.less        = lt_q;
    assign bus.equal       = eq_q;
    assign bus.greater     = gt_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed corner cases and random ops on a 16-bit
// instance against an arithmetic reference model, plus an 8-bit instance.
module tb_seq_alu;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] q;
    logic [15:0] hi;
    logic        ovf, lt, eq, gt, zero, dbz;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_alu_if #(.WIDTH(16)) bus16 ();
  seq_alu_if #(.WIDTH(8))  bus8 ();

  seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: plain arithmetic on the operands
  function automatic exp_t model16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [31:0] p;
    e = '{q: 16'h0, hi: 16'h0, ovf: 1'b0, lt: 1'b0, eq: 1'b0, gt: 1'b0,
          zero: 1'b0, dbz: 1'b0, lat: 1};
    case (op)
      OP_ADD:  begin p = 32'(a) + 32'(b); e.q = p[15:0]; e.ovf = (p > 32'hFFFF); end
      OP_SUB:  begin e.q = a - b; e.ovf = (a >= b); end
      OP_NEG:  e.q = 16'(0 - int'(b));
      OP_SCMP: begin
        e.q = a - b;
        e.lt = ($signed(a) < $signed(b));
        e.eq = (a == b);
        e.gt = ($signed(a) > $signed(b));
      end
      OP_UCMP: begin e.q = a - b; e.lt = (a < b); e.eq = (a == b); e.gt = (a > b); end
      OP_AND:  e.q = a & b;
      OP_OR:   e.q = a | b;
      OP_XOR:  e.q = a ^ b;
      OP_NOT:  e.q = ~b;
      OP_ARS:  begin e.q = 16'($signed(b) >>> 1); e.ovf = b[0]; end
      OP_LRS:  begin e.q = b / 16'd2; e.ovf = b[0]; end
      OP_LROT: e.q = 16'((32'(b) * 2) % 65536) | (b / 16'h8000);
      OP_RROT: e.q = (b / 16'd2) | (b[0] ? 16'h8000 : 16'h0000);
      OP_MUL:  begin
        p = 32'(a) * 32'(b);
        e.q = p[15:0]; e.hi = p[31:16]; e.ovf = (p > 32'hFFFF); e.lat = 17;
      end
      OP_DIV:  begin
        if (b == 16'h0) begin e.q = 16'hFFFF; e.hi = a; e.dbz = 1'b1; end
        else begin e.q = a / b; e.hi = a % b; e.lat = 17; end
      end
      default: ;
    endcase
    e.zero = (e.q == 16'h0) && (e.hi == 16'h0);
    return e;
  endfunction

  // driver: issue one op in the current cycle, wait for done, check all outputs
  task automatic run16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit scramble);
    exp_t e;
    int   cyc;
    string t;
    e = model16(op, a, b);
    t = $sformatf("op=%b a=%h b=%h", op, a, b);
    bus16.start = 1'b1; bus16.op = op; bus16.a = a; bus16.b = b;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    if (scramble) begin
      bus16.op = 5'($urandom); bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    end
    cyc = 1;
    while (bus16.done !== 1'b1 && cyc < 40) begin
      chk({"busy_run ", t}, 32'(bus16.busy), 32'd1);
      @(posedge clk); #1;
      cyc++;
    end
    chk({"latency ", t}, 32'(cyc), 32'(e.lat));
    chk({"busy_done ", t}, 32'(bus16.busy), 32'd0);
    chk({"q ", t}, 32'(bus16.q), 32'(e.q));
    chk({"q_hi ", t}, 32'(bus16.q_hi), 32'(e.hi));
    chk({"overflow ", t}, 32'(bus16.overflow), 32'(e.ovf));
    chk({"less ", t}, 32'(bus16.less), 32'(e.lt));
    chk({"equal ", t}, 32'(bus16.equal), 32'(e.eq));
    chk({"greater ", t}, 32'(bus16.greater), 32'(e.gt));
    chk({"zero ", t}, 32'(bus16.zero), 32'(e.zero));
    chk({"div_by_zero ", t}, 32'(bus16.div_by_zero), 32'(e.dbz));
  endtask

  task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int lat, input logic [7:0] eq_lo, input logic [7:0] eq_hi);
    int cyc;
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    cyc = 1;
    while (bus8.done !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w8_latency", 32'(cyc), 32'(lat));
    chk("w8_q", 32'(bus8.q), 32'(eq_lo));
    chk("w8_q_hi", 32'(bus8.q_hi), 32'(eq_hi));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 32'(bus16.busy), 32'd0);
    chk({tag, " done"}, 32'(bus16.done), 32'd0);
    chk({tag, " q"}, 32'(bus16.q), 32'd0);
    chk({tag, " q_hi"}, 32'(bus16.q_hi), 32'd0);
    chk({tag, " flags"}, 32'({bus16.overflow, bus16.less, bus16.equal, bus16.greater,
                              bus16.zero, bus16.div_by_zero}), 32'd0);
    chk({tag, " state"}, 32'(bus16.state_dbg), 32'(ST_IDLE));
  endtask

  logic [4:0] op_tab [15] = '{OP_ADD, OP_SUB, OP_NEG, OP_SCMP, OP_UCMP, OP_AND, OP_OR,
                              OP_XOR, OP_NOT, OP_ARS, OP_LRS, OP_LROT, OP_RROT,
                              OP_MUL, OP_DIV};

  initial begin
    int          ndone;
    int          cyc;
    logic [4:0]  rop;
    logic [15:0] ra, rb;

    rst = 1'b1;
    bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0;
    bus8.start  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset w8 q", 32'(bus8.q), 32'd0);
    rst = 1'b0;

    // boundary single-cycle cases
    run16(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    chk("add_wrap q", 32'(bus16.q), 32'h0);
    chk("add_wrap ovf", 32'(bus16.overflow), 32'd1);
    run16(OP_SCMP, 16'h8000, 16'h0001, 1'b0);
    chk("scmp_less", 32'(bus16.less), 32'd1);
    run16(OP_UCMP, 16'h8000, 16'h0001, 1'b0);
    chk("ucmp_greater", 32'(bus16.greater), 32'd1);
    run16(OP_SCMP, 16'h1234, 16'h1234, 1'b0);
    chk("scmp_equal", 32'(bus16.equal), 32'd1);

    // MUL with a start pulse during busy that must be ignored
    bus16.start = 1'b1; bus16.op = OP_MUL; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    cyc = 1;
    while (bus16.done !== 1'b1 && cyc < 40) begin
      chk("mul_busy", 32'(bus16.busy), 32'd1);
      if (cyc == 5) begin
        bus16.start = 1'b1; bus16.op = OP_ADD; bus16.a = 16'h0001; bus16.b = 16'h0001;
      end else begin
        bus16.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("mul_latency", 32'(cyc), 32'd17);
    chk("mul_q", 32'(bus16.q), 32'h0001);
    chk("mul_q_hi", 32'(bus16.q_hi), 32'hFFFE);
    chk("mul_ovf", 32'(bus16.overflow), 32'd1);
    @(posedge clk); #1;
    chk("mul_no_extra_done", 32'(bus16.done), 32'd0);
    chk("mul_no_extra_busy", 32'(bus16.busy), 32'd0);

    run16(OP_DIV, 16'h0064, 16'h0007, 1'b0);
    chk("div_q", 32'(bus16.q), 32'h000E);
    chk("div_rem", 32'(bus16.q_hi), 32'h0002);
    run16(OP_DIV, 16'h0064, 16'h0000, 1'b0);
    chk("div0_dbz", 32'(bus16.div_by_zero), 32'd1);
    run16(5'b00000, 16'h1234, 16'h5678, 1'b0);

    // reset in the middle of a MUL aborts it with no done
    run16(OP_DIV, 16'h0064, 16'h0000, 1'b0);
    bus16.start = 1'b1; bus16.op = OP_MUL; bus16.a = 16'h1234; bus16.b = 16'h5678;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus16.done === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run16(OP_ADD, 16'h0002, 16'h0003, 1'b0);
    chk("after_abort_add", 32'(bus16.q), 32'h0005);

    // random back-to-back ops, operands scrambled while in flight
    for (int i = 0; i < 60; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 14)];
      ra  = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'h0000;
        1:       rb = ra;
        2:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      run16(rop, ra, rb, 1'b1);
    end

    // 8-bit instance
    run8(OP_MUL, 8'hFF, 8'h02, 9, 8'hFE, 8'h01);
    run8(OP_LROT, 8'h00, 8'h80, 1, 8'h01, 8'h00);
    run8(OP_DIV, 8'hC8, 8'h07, 9, 8'h1C, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
